toggle_strobe_gen: RTL and testbench
====================================

// Module: toggle_strobe_gen
// PURPOSE
//  Generates the T (toggle-enable) strobe for the T flip-flop stage and the
//  counter bank built from it. A programmable prescaler issues one-cycle T
//  pulses every (Div+1) clocks, either continuously or as a fixed-length
//  burst. A start/stop FSM reports Busy and Done to the controlling logic.
// PARAMETERS
//  DIV_W  8  width of the prescaler divide value Div
//  CNT_W  8  width of the burst length and of the pulse counter
// PORTS
//  Clock        in   1      rising-edge clock; the only clock in the block
//  Clear        in   1      asynchronous, active-low reset
//  Start        in   1      level, sampled each edge; starts a run when IDLE
//  Stop         in   1      level, sampled each edge; aborts a run
//  Mode         in   1      0 = continuous, 1 = burst; latched on Start
//  Div          in   DIV_W  strobe period is Div+1 clocks; latched on Start
//  Burst_Len    in   CNT_W  number of T pulses in a burst; latched on Start
//  T            out  1      registered one-cycle toggle strobe to the T FF stage
//  Busy         out  1      registered; 1 while state is RUN
//  Done         out  1      registered one-cycle pulse when a burst completes
//  Pulse_Count  out  CNT_W  registered count of T pulses issued in the current/last run
// BEHAVIOUR
//  - Clear=0, asynchronous and at any time: state=IDLE, presc=0, T=0, Busy=0,
//    Done=0, Pulse_Count=0, latched Div/Mode/Burst_Len=0. A run in progress
//    is lost with no Done pulse.
//  - States: IDLE, RUN, DONE. All outputs are registered, with no combinational paths.
//  - IDLE:
//    - Start=1 and Stop=0 at edge k: latch Div, Mode, Burst_Len; presc<=0;
//      Pulse_Count<=0; Busy<=1; next state is RUN.
//    - Exception: Mode=1 with Burst_Len=0 goes straight to DONE. No T pulses.
//    - Start and Stop together: Stop wins and the block stays IDLE.
//  - RUN, at each edge, in priority order:
//    1. Stop=1: go to IDLE. T<=0, Busy<=0, no Done. Pulse_Count holds.
//    2. presc==Div_l: presc<=0, T<=1, Pulse_Count<=Pulse_Count+1.
//       In burst mode, if the new count equals Burst_Len_l: go to DONE,
//       Busy<=0, Done<=1.
//    3. Otherwise: presc<=presc+1, T<=0.
//  - Timing: the first T is high in the cycle after edge k+Div+1, then every
//    Div+1 cycles. With Div=0, T is high every cycle from edge k+1.
//  - DONE: lasts exactly one cycle with Done=1 (the last T is high in that
//    same cycle). Next edge: IDLE, Done<=0, T<=0. Start is ignored in DONE.
//  - Start in RUN is ignored; inputs are re-latched only from IDLE.
//  - Continuous mode: Pulse_Count wraps modulo 2^CNT_W and the run continues
//    until Stop or Clear.
//  - Pulse_Count holds its final value in IDLE until the next accepted Start.
//  - Div, Mode and Burst_Len changes during RUN have no effect.
// TESTING
//  1. Clear low mid-run (Div=3, continuous) -> every output is 0 immediately
//     (asynchronously); after release the block is IDLE and a T pulse needs a new Start.
//  2. Burst, Div=2, Burst_Len=4 -> T high in cycles k+3, k+6, k+9, k+12;
//     Done high in cycle k+12 only; Pulse_Count=4; Busy low from k+12.
//  3. Continuous, Div=0 -> T high every cycle from k+1. After 300 cycles,
//     Pulse_Count=300 mod 256=44. Stop -> T=0, Busy=0 next cycle, Done never asserted.
//  4. Stop in the same cycle as the terminal pulse (Burst_Len=2, Div=1) ->
//     no second T, no Done, Pulse_Count=1, state IDLE.
//  5. Start and Stop together in IDLE -> stays IDLE. Mode=1 with
//     Burst_Len=0 -> one-cycle Done, no T. Start during RUN -> no re-latch.
//  6. Div and Burst_Len changed during RUN (Div 2->7) -> period stays 3 and
//     the burst length is unchanged.

Source files
------------

// File: rtl/toggle_strobe_gen.sv
// Prescaled T-strobe generator for the T flip-flop stage and its counter bank.
// Issues one-cycle T pulses every Div+1 clocks, continuously or as a fixed-length burst.
module toggle_strobe_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    input  logic [DIV_W-1:0] Div,
    input  logic [CNT_W-1:0] Burst_Len,
    output logic             T,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Pulse_Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [DIV_W-1:0]   presc_reg,  presc_next;
    logic [DIV_W-1:0]   div_reg,    div_next;
    logic               mode_reg,   mode_next;
    logic [CNT_W-1:0]   burst_reg,  burst_next;
    logic [CNT_W-1:0]   count_reg,  count_next;
    logic               t_reg,      t_next;
    logic               busy_reg,   busy_next;
    logic               done_reg,   done_next;
    logic [CNT_W-1:0]   count_inc;

    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            div_reg   <= '0;
            mode_reg  <= 1'b0;
            burst_reg <= '0;
            count_reg <= '0;
            t_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            div_reg   <= div_next;
            mode_reg  <= mode_next;
            burst_reg <= burst_next;
            count_reg <= count_next;
            t_reg     <= t_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // T and Done are one-cycle pulses, so they default low every cycle.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        div_next   = div_reg;
        mode_next  = mode_reg;
        burst_next = burst_reg;
        count_next = count_reg;
        t_next     = 1'b0;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start && !Stop) begin
                    div_next   = Div;
                    mode_next  = Mode;
                    burst_next = Burst_Len;
                    presc_next = '0;
                    count_next = '0;
                    if (Mode && (Burst_Len == '0)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = RUN;
                        busy_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (Stop) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (presc_reg == div_reg) begin
                    presc_next = '0;
                    t_next     = 1'b1;
                    count_next = count_inc;
                    if (mode_reg && (count_inc == burst_reg)) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign T           = t_reg;
    assign Busy        = busy_reg;
    assign Done        = done_reg;
    assign Pulse_Count = count_reg;

endmodule

// File: tb/tb_toggle_strobe_gen.sv
// Directed bench for toggle_strobe_gen: burst/continuous timing, Stop/Clear aborts,
// zero-length bursts and input stability during a run.
module tb_toggle_strobe_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 8;

    logic             Clock;
    logic             Clear;
    logic             Start;
    logic             Stop;
    logic             Mode;
    logic [DIV_W-1:0] Div;
    logic [CNT_W-1:0] Burst_Len;
    logic             T;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Pulse_Count;

    int checks   = 0;
    int failures = 0;

    toggle_strobe_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .Start      (Start),
        .Stop       (Stop),
        .Mode       (Mode),
        .Div        (Div),
        .Burst_Len  (Burst_Len),
        .T          (T),
        .Busy       (Busy),
        .Done       (Done),
        .Pulse_Count(Pulse_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic t_e, input logic b_e,
                             input logic d_e, input logic [31:0] c_e);
        check({tag, ".T"},     {31'd0, T},    {31'd0, t_e});
        check({tag, ".Busy"},  {31'd0, Busy}, {31'd0, b_e});
        check({tag, ".Done"},  {31'd0, Done}, {31'd0, d_e});
        check({tag, ".Count"}, {24'd0, Pulse_Count}, c_e);
    endtask

    initial begin
        Clear = 1'b0; Start = 1'b0; Stop = 1'b0; Mode = 1'b0;
        Div = '0; Burst_Len = '0;
        tick(); tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 0);
        Clear = 1'b1;
        tick();
        check_all("idle_after_reset", 1'b0, 1'b0, 1'b0, 0);

        // Burst, Div=2, Burst_Len=4: T at k+3,6,9,12, Done at k+12
        $display("test burst div=2 len=4");
        Start = 1'b1; Mode = 1'b1; Div = 8'd2; Burst_Len = 8'd4;
        tick();
        Start = 1'b0;
        check_all("burst_k", 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            check({"burst_T"},    {31'd0, T},    {31'd0, (i % 3 == 0) && (i <= 12)});
            check({"burst_Done"}, {31'd0, Done}, {31'd0, i == 12});
            check({"burst_Busy"}, {31'd0, Busy}, {31'd0, i < 12});
            check({"burst_Count"}, {24'd0, Pulse_Count}, (i <= 12) ? i / 3 : 4);
        end

        // Continuous, Div=0: T every cycle, count wraps, Stop ends without Done
        $display("test continuous div=0 300 cycles");
        Start = 1'b1; Mode = 1'b0; Div = 8'd0; Burst_Len = 8'd5;
        tick();
        Start = 1'b0;
        check_all("cont_k", 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            check("cont_T", {31'd0, T}, 32'd1);
            check("cont_Done", {31'd0, Done}, 32'd0);
        end
        check("cont_count_wrap", {24'd0, Pulse_Count}, 32'd44);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check_all("cont_stop", 1'b0, 1'b0, 1'b0, 44);
        tick();
        check_all("cont_idle", 1'b0, 1'b0, 1'b0, 44);

        // Clear low mid-run while T is high: outputs drop without a clock edge
        $display("test async clear mid-run div=3");
        Start = 1'b1; Mode = 1'b0; Div = 8'd3;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check_all("clr_before", 1'b1, 1'b1, 1'b0, 1);
        #2;
        Clear = 1'b0;
        #1;
        check_all("clr_async", 1'b0, 1'b0, 1'b0, 0);
        tick();
        Clear = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_all("clr_idle", 1'b0, 1'b0, 1'b0, 0);
        end

        // Stop coincides with the terminal pulse of a 2-pulse burst
        $display("test stop on terminal pulse len=2 div=1");
        Start = 1'b1; Mode = 1'b1; Div = 8'd1; Burst_Len = 8'd2;
        tick();
        Start = 1'b0;
        tick();
        check_all("stopterm_k1", 1'b0, 1'b1, 1'b0, 0);
        tick();
        check_all("stopterm_k2", 1'b1, 1'b1, 1'b0, 1);
        tick();
        check_all("stopterm_k3", 1'b0, 1'b1, 1'b0, 1);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check_all("stopterm_k4", 1'b0, 1'b0, 1'b0, 1);
        tick();
        check_all("stopterm_k5", 1'b0, 1'b0, 1'b0, 1);

        // Start and Stop together in IDLE: Stop wins
        $display("test start+stop in idle");
        Start = 1'b1; Stop = 1'b1; Mode = 1'b0; Div = 8'd0;
        tick();
        check_all("startstop_1", 1'b0, 1'b0, 1'b0, 1);
        tick();
        Start = 1'b0; Stop = 1'b0;
        check_all("startstop_2", 1'b0, 1'b0, 1'b0, 1);

        // Zero-length burst: one Done cycle, no T; Start held through DONE is ignored
        $display("test zero-length burst");
        Start = 1'b1; Mode = 1'b1; Div = 8'd0; Burst_Len = 8'd0;
        tick();
        check_all("zlen_k", 1'b0, 1'b0, 1'b1, 0);
        tick();
        Start = 1'b0;
        check_all("zlen_k1", 1'b0, 1'b0, 1'b0, 0);
        tick();
        check_all("zlen_k2", 1'b0, 1'b0, 1'b0, 0);

        // Start re-asserted during RUN with new settings must not re-latch
        $display("test start during run div=1 continuous");
        Start = 1'b1; Mode = 1'b0; Div = 8'd1; Burst_Len = 8'd0;
        tick();
        Mode = 1'b1; Div = 8'd5; Burst_Len = 8'd1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("rerun_T", {31'd0, T}, {31'd0, i % 2 == 0});
            check("rerun_Done", {31'd0, Done}, 32'd0);
            check("rerun_Busy", {31'd0, Busy}, 32'd1);
        end
        check("rerun_count", {24'd0, Pulse_Count}, 32'd3);
        Start = 1'b0; Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check_all("rerun_stop", 1'b0, 1'b0, 1'b0, 3);

        // Div and Burst_Len changed during a burst: period 3, length 3 kept
        $display("test settings change during burst div=2 len=3");
        Start = 1'b1; Mode = 1'b1; Div = 8'd2; Burst_Len = 8'd3;
        tick();
        Start = 1'b0; Div = 8'd7; Burst_Len = 8'd10; Mode = 1'b0;
        check_all("chg_k", 1'b0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("chg_T", {31'd0, T}, {31'd0, (i % 3 == 0) && (i <= 9)});
            check("chg_Done", {31'd0, Done}, {31'd0, i == 9});
            check("chg_Busy", {31'd0, Busy}, {31'd0, i < 9});
        end
        check("chg_count", {24'd0, Pulse_Count}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
